mac_vec_engine: RTL and testbench

MAC_VEC_ENGINE -- requirements
Module: mac_vec_engine

---
 rtl/mac_vec_engine.sv | 173 +++++++++++++++++
 tb/tb_mac_vec_engine.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_vec_engine.sv
// mac_vec_engine
//   Vector multiply-accumulate engine. Accepts VEC_LEN operand pairs
//   (a, b), multiplies each pair, and accumulates the products into an
//   ACC_W-bit accumulator. The products are signed or unsigned, as chosen
//   by signed_mode. The dot product is then offered on a valid/ready
//   result port.
//
// Handshakes (both ports use strict valid/ready semantics):
//   A transfer happens at a rising clk edge where valid and ready are both
//   high. The producer holds its data stable while valid is high. Ready
//   never depends combinationally on valid.
//     in_valid/in_ready   : one operand pair per transfer
//     out_valid/out_ready : one dot-product result per transfer
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    operand pair valid
//   in_ready    engine accepts operands (high only in ACCUM)
//   a, b        DATA_W-bit operands
//   signed_mode 1 = two's complement operands, 0 = unsigned; sampled on the
//               first accept of each vector
//   clear       synchronous abort of the current vector; wins over
//               everything except reset
//   out_valid   dot-product result valid (high only in DONE)
//   out_ready   consumer accepts the result
//   acc_out     accumulator register (partial sum while accumulating)
//   overflow    sticky overflow flag for the current vector
module mac_vec_engine #(
  parameter int DATA_W  = 4,
  parameter int ACC_W   = 12,
  parameter int VEC_LEN = 8,
  parameter int SAT     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              signed_mode,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow
);

  if (ACC_W < 2*DATA_W+1) begin : g_bad_acc_w
    $error("mac_vec_engine: ACC_W must be at least 2*DATA_W+1");
  end
  if (VEC_LEN < 2 || VEC_LEN > 256) begin : g_bad_vec_len
    $error("mac_vec_engine: VEC_LEN must be in 2..256");
  end

  localparam int CNT_W = $clog2(VEC_LEN);
  localparam int PRD_W = 2*DATA_W;
  localparam int EXT_W = ACC_W + 1 - PRD_W;

  typedef enum logic [1:0] {ACCUM = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               drain_cnt;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic               v1;
  logic               mode_q;
  logic [ACC_W-1:0]   acc;
  logic               ovf;

  logic               accept;
  logic               last_accept;
  logic [PRD_W-1:0]   a_x;
  logic [PRD_W-1:0]   b_x;
  logic [PRD_W-1:0]   prod;
  logic [ACC_W:0]     prod_ext;
  logic [ACC_W:0]     acc_ext;
  logic [ACC_W:0]     sum;
  logic               add_ovf;
  logic [ACC_W-1:0]   sat_val;
  logic [ACC_W-1:0]   add_res;

  assign in_ready    = (state == ACCUM);
  assign out_valid   = (state == DONE);
  assign acc_out     = acc;
  assign overflow    = ovf;
  assign accept      = in_valid & in_ready;
  assign last_accept = accept && (cnt == CNT_W'(VEC_LEN-1));

  // Stage 2 datapath. The operands are extended to the product width
  // first, so the low PRD_W bits of one multiply give the correct product
  // in both modes. The sum is then formed one bit wider than the
  // accumulator, so an out-of-range result shows up in the top bits.
  always_comb begin
    a_x      = mode_q ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
    b_x      = mode_q ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {{DATA_W{1'b0}}, b_q};
    prod     = a_x * b_x;
    prod_ext = {{EXT_W{mode_q & prod[PRD_W-1]}}, prod};
    acc_ext  = {mode_q & acc[ACC_W-1], acc};
    sum      = acc_ext + prod_ext;
    // Signed: the top two bits disagree on overflow. Unsigned: carry out.
    add_ovf  = mode_q ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
    // The overflow direction follows the sign of the product: in signed
    // mode, only a negative product can underflow.
    if (mode_q) begin
      sat_val = prod[PRD_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sat_val = {ACC_W{1'b1}};
    end
    add_res  = (SAT != 0 && add_ovf) ? sat_val : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      cnt       <= '0;
      drain_cnt <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      v1        <= 1'b0;
      mode_q    <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else if (clear) begin
      state     <= ACCUM;
      cnt       <= '0;
      drain_cnt <= 1'b0;
      v1        <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else begin
      // Stage 1
      v1 <= accept;
      if (accept) begin
        a_q <= a;
        b_q <= b;
        if (cnt == '0) mode_q <= signed_mode;
      end
      // Stage 2
      if (v1) begin
        acc <= add_res;
        ovf <= ovf | add_ovf;
      end
      case (state)
        ACCUM: begin
          if (last_accept) begin
            cnt       <= '0;
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else if (accept) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // Two cycles let the last pair pass through both pipeline stages.
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_vec_engine.sv
// Testbench for mac_vec_engine. Three instances share one stimulus stream:
// the default configuration, ACC_W=9 saturating, and ACC_W=9 wrapping.
// Expected results come from an integer model of the dot-product rules.
module tb_mac_vec_engine;
  localparam int DW = 4;
  localparam int VL = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, signed_mode, clear, out_ready;
  logic [DW-1:0] a, b;
  logic          in_ready0, out_valid0, ovf0;
  logic          in_ready1, out_valid1, ovf1;
  logic          in_ready2, out_valid2, ovf2;
  logic [11:0]   acc0;
  logic [8:0]    acc1, acc2;

  mac_vec_engine #(.DATA_W(DW), .ACC_W(12), .VEC_LEN(VL), .SAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .signed_mode(signed_mode), .clear(clear),
    .out_valid(out_valid0), .out_ready(out_ready), .acc_out(acc0), .overflow(ovf0));

  mac_vec_engine #(.DATA_W(DW), .ACC_W(9), .VEC_LEN(VL), .SAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .signed_mode(signed_mode), .clear(clear),
    .out_valid(out_valid1), .out_ready(out_ready), .acc_out(acc1), .overflow(ovf1));

  mac_vec_engine #(.DATA_W(DW), .ACC_W(9), .VEC_LEN(VL), .SAT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .signed_mode(signed_mode), .clear(clear),
    .out_valid(out_valid2), .out_ready(out_ready), .acc_out(acc2), .overflow(ovf2));

  int n_checks = 0;
  int n_fail   = 0;
  int va[VL];
  int vb[VL];
  bit vmode;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input int v);
    return (v >= (1 << (DW-1))) ? longint'(v - (1 << DW)) : longint'(v);
  endfunction

  // Reference model: the dot product of va/vb in mode vmode, computed for an
  // accumulator of width w. With sat set, an out-of-range result is clamped;
  // otherwise it wraps.
  function automatic void model(input int w, input bit sat,
                                output logic [31:0] res, output logic [31:0] ovf);
    longint acc = 0;
    longint p, s, lo, hi, m;
    bit o = 1'b0;
    m  = longint'(1) << w;
    lo = vmode ? -(m/2) : 0;
    hi = vmode ? (m/2 - 1) : (m - 1);
    for (int i = 0; i < VL; i++) begin
      p = vmode ? sx(va[i]) * sx(vb[i]) : longint'(va[i] * vb[i]);
      s = acc + p;
      if (s > hi || s < lo) begin
        o = 1'b1;
        if (sat) s = (s > hi) ? hi : lo;
        else begin
          s = ((s % m) + m) % m;
          if (s > hi) s = s - m;
        end
      end
      acc = s;
    end
    res = 32'(acc & (m - 1));
    ovf = {31'b0, o};
  endfunction

  // driver: VEC_LEN pairs from va/vb. Optional idle gaps. signed_mode is
  // scrambled after the first pair, and the engine must ignore that.
  // Returns at the falling edge after the last accept.
  task automatic drive_pairs(input bit gaps);
    for (int i = 0; i < VL; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          a = DW'($urandom);
          signed_mode = 1'($urandom);
          @(negedge clk);
        end
      end
      in_valid    = 1'b1;
      a           = DW'(va[i]);
      b           = DW'(vb[i]);
      signed_mode = (i == 0) ? vmode : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // latency and result check, starting at the falling edge after edge k
  task automatic check_result(input string tag);
    logic [31:0] r, o;
    check({tag, "_lat_k_valid"}, {31'b0, out_valid0}, 0);
    check({tag, "_lat_k_ready"}, {31'b0, in_ready0}, 0);
    @(negedge clk);
    check({tag, "_lat_k1_valid"}, {31'b0, out_valid0}, 0);
    @(negedge clk);
    check({tag, "_lat_k2_valid0"}, {31'b0, out_valid0}, 1);
    check({tag, "_lat_k2_valid1"}, {31'b0, out_valid1}, 1);
    check({tag, "_lat_k2_valid2"}, {31'b0, out_valid2}, 1);
    model(12, 1'b1, r, o);
    check({tag, "_acc0"}, 32'(acc0), r);
    check({tag, "_ovf0"}, {31'b0, ovf0}, o);
    model(9, 1'b1, r, o);
    check({tag, "_acc1_sat"}, 32'(acc1), r);
    check({tag, "_ovf1_sat"}, {31'b0, ovf1}, o);
    model(9, 1'b0, r, o);
    check({tag, "_acc2_wrap"}, 32'(acc2), r);
    check({tag, "_ovf2_wrap"}, {31'b0, ovf2}, o);
  endtask

  // hold the result with out_ready low for some cycles, then take it
  task automatic finish_vec(input string tag, input int hold);
    logic [11:0] held;
    held = acc0;
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'b0, out_valid0}, 1);
      check({tag, "_hold_acc"}, 32'(acc0), 32'(held));
      check({tag, "_hold_ready"}, {31'b0, in_ready0}, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_hs_valid"}, {31'b0, out_valid0}, 0);
    check({tag, "_hs_acc0"}, 32'(acc0), 0);
    check({tag, "_hs_acc1"}, 32'(acc1), 0);
    check({tag, "_hs_ovf1"}, {31'b0, ovf1}, 0);
    check({tag, "_hs_ready"}, {31'b0, in_ready0}, 1);
  endtask

  task automatic fill(input int fa, input int fb, input bit m);
    for (int i = 0; i < VL; i++) begin
      va[i] = fa;
      vb[i] = fb;
    end
    vmode = m;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    signed_mode = 1'b0; clear = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_acc", 32'(acc0), 0);
    check("rst_ovf", {31'b0, ovf0}, 0);
    check("rst_out_valid", {31'b0, out_valid0}, 0);
    check("rst_in_ready", {31'b0, in_ready0}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // unsigned 8 x (15,15), then backpressure
    fill(15, 15, 1'b0);
    drive_pairs(1'b0);
    check_result("uns");
    check("uns_acc0_const", 32'(acc0), 1800);
    check("uns_acc1_sat_const", 32'(acc1), 511);
    check("uns_ovf1_const", {31'b0, ovf1}, 1);
    check("uns_acc2_wrap_const", 32'(acc2), 264);
    check("uns_ovf2_const", {31'b0, ovf2}, 1);
    finish_vec("bp", 5);

    // signed 8 x (-8, 7)
    fill(8, 7, 1'b1);
    drive_pairs(1'b0);
    check_result("sgn");
    check("sgn_acc0_const", 32'(acc0), 32'h0E40);
    check("sgn_ovf0_const", {31'b0, ovf0}, 0);
    finish_vec("sgn", 1);

    // clear mid-vector, with a pair offered in the same cycle
    in_valid = 1'b1; a = 4'd15; b = 4'd15; signed_mode = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    check("clr_acc", 32'(acc0), 0);
    check("clr_in_ready", {31'b0, in_ready0}, 1);
    @(negedge clk);
    check("clr_no_leak", 32'(acc0), 0);
    fill(1, 2, 1'b0);
    drive_pairs(1'b0);
    check_result("clr");
    check("clr_acc_const", 32'(acc0), 16);
    finish_vec("clr", 0);

    // reset asserted during DRAIN
    fill(5, 5, 1'b0);
    drive_pairs(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rstd_acc", 32'(acc0), 0);
    check("rstd_ovf", {31'b0, ovf0}, 0);
    check("rstd_out_valid", {31'b0, out_valid0}, 0);
    check("rstd_in_ready", {31'b0, in_ready0}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstd_after_acc", 32'(acc0), 0);
    check("rstd_after_valid", {31'b0, out_valid0}, 0);
    fill(3, 3, 1'b0);
    drive_pairs(1'b0);
    check_result("rstd");
    check("rstd_acc_const", 32'(acc0), 72);
    finish_vec("rstd", 0);

    // random vectors
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < VL; i++) begin
        va[i] = int'($urandom_range(0, 15));
        vb[i] = int'($urandom_range(0, 15));
      end
      vmode = 1'($urandom_range(0, 1));
      drive_pairs(1'b1);
      check_result("rnd");
      finish_vec("rnd", int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
